// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in serial-out shifter with a one-word hold buffer
// so back-to-back words stream out with no idle bit between them.
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             x,
  output logic             x_valid,
  output logic             frame_done,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t           state;
  logic [WIDTH-1:0] shreg, hold;
  logic [CW-1:0]    cnt;
  logic             hold_full, accept, last;
  assign accept     = in_valid && !hold_full;
  assign last       = state == SHIFT && cnt == LAST;
  assign in_ready   = !hold_full;
  assign x_valid    = state == SHIFT;
  assign x          = x_valid && (MSB_FIRST ? shreg[WIDTH-1] : shreg[0]);
  assign frame_done = last;
  assign busy       = x_valid || hold_full;
  // hold_full is never set on the last bit, so a same-cycle accept there always loads directly
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state     <= IDLE;
      shreg     <= '0;
      hold      <= '0;
      cnt       <= '0;
      hold_full <= 1'b0;
    end else if (state == IDLE) begin
      if (accept) begin
        shreg <= in_data;
        cnt   <= '0;
        state <= SHIFT;
      end
    end else if (!last) begin
      cnt   <= cnt + 1'b1;
      shreg <= MSB_FIRST ? shreg << 1 : shreg >> 1;
      if (accept) begin
        hold      <= in_data;
        hold_full <= 1'b1;
      end
    end else if (hold_full) begin
      shreg     <= hold;
      cnt       <= '0;
      hold_full <= 1'b0;
    end else if (accept) begin
      shreg <= in_data;
      cnt   <= '0;
    end else begin
      state <= IDLE;
    end
endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: vector table, corner sequences and a word-queue reference
// model that checks an MSB-first and an LSB-first instance every cycle.
module tb_piso_serializer;
  localparam int W = 8;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic rdy_m, x_m, v_m, fd_m, busy_m;
  logic rdy_l, x_l, v_l, fd_l, busy_l;
  int checks = 0, errors = 0;

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy_m),
    .x(x_m), .x_valid(v_m), .frame_done(fd_m), .busy(busy_m));
  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy_l),
    .x(x_l), .x_valid(v_l), .frame_done(fd_l), .busy(busy_l));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO of accepted words plus the bit position within the head word.
  logic [W-1:0] words[$];
  int pos = 0, q_p, q_n;
  logic acc_p;
  logic [W-1:0] d_p;
  logic e_v, e_xm, e_xl, e_fd, e_rdy;

  always @(negedge rst) begin
    words.delete();
    pos = 0;
  end

  always @(posedge clk) if (rst) begin
    q_p   = words.size() * W - pos;
    acc_p = in_valid && q_p <= W;
    d_p   = in_data;
    if (q_p > 0) begin
      pos++;
      if (pos == W) begin
        pos = 0;
        void'(words.pop_front());
      end
    end
    if (acc_p) words.push_back(d_p);
  end

  always @(negedge clk) begin
    q_n   = words.size() * W - pos;
    e_v   = q_n > 0;
    e_rdy = q_n <= W;
    e_xm  = 1'b0;
    e_xl  = 1'b0;
    e_fd  = 1'b0;
    if (e_v) begin
      e_xm = words[0][W-1-pos];
      e_xl = words[0][pos];
      e_fd = pos == W - 1;
    end
    chk("model_msb", {v_m, x_m, fd_m, rdy_m, busy_m}, {e_v, e_xm, e_fd, e_rdy, e_v});
    chk("model_lsb", {v_l, x_l, fd_l, rdy_l, busy_l}, {e_v, e_xl, e_fd, e_rdy, e_v});
  end

  typedef struct {
    logic [W-1:0] data;
    logic [W-1:0] msb_seq;
    logic [W-1:0] lsb_seq;
  } vec_t;
  vec_t vecs[6];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic rst_chk(input string name);
    chk({name, "_m"}, {x_m, v_m, rdy_m, fd_m, busy_m}, 5'b00100);
    chk({name, "_l"}, {x_l, v_l, rdy_l, fd_l, busy_l}, 5'b00100);
  endtask

  // Sequences list emitted bits left to right, so bit 7 is the first one on x.
  task automatic single(input vec_t v);
    in_data  = v.data;
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    for (int k = 1; k <= W; k++) begin
      chk("single_msb", {v_m, x_m, fd_m}, {1'b1, v.msb_seq[W-k], k == W});
      chk("single_lsb", {v_l, x_l, fd_l}, {1'b1, v.lsb_seq[W-k], k == W});
      cyc();
    end
    chk("single_end", {v_m, v_l, busy_m, busy_l}, 4'b0000);
  endtask

  logic [23:0] s24;
  logic [15:0] s16;

  initial begin
    vecs[0] = '{8'h01, 8'b0000_0001, 8'b1000_0000};
    vecs[1] = '{8'h96, 8'b1001_0110, 8'b0110_1001};
    vecs[2] = '{8'h81, 8'b1000_0001, 8'b1000_0001};
    vecs[3] = '{8'hF0, 8'b1111_0000, 8'b0000_1111};
    vecs[4] = '{8'h3C, 8'b0011_1100, 8'b0011_1100};
    vecs[5] = '{8'hA5, 8'b1010_0101, 8'b1010_0101};

    #2 rst = 1'b0;
    #1 rst_chk("reset_initial");
    cyc();
    cyc();
    #2 rst = 1'b1;
    cyc();

    foreach (vecs[i]) single(vecs[i]);

    // Back-to-back A5, 3C, FF with in_valid held high.
    s24 = {8'hA5, 8'h3C, 8'hFF};
    in_data  = 8'hA5;
    in_valid = 1'b1;
    cyc();
    for (int k = 1; k <= 25; k++) begin
      if (k <= 24) begin
        chk("b2b_msb", {v_m, x_m, fd_m}, {1'b1, s24[24-k], k % 8 == 0});
        chk("b2b_lsb", {v_l, x_l, fd_l}, {1'b1, s24[24-k], k % 8 == 0});
      end else chk("b2b_end", {v_m, busy_m}, 2'b00);
      if (k <= 9) chk("b2b_ready", rdy_m, k == 1 || k == 9);
      if (k == 1) in_data = 8'h3C;
      if (k == 2) in_data = 8'hFF;
      if (k == 10) in_valid = 1'b0;
      cyc();
    end

    // A word offered exactly on the last bit follows with no gap.
    s16 = {8'hA5, 8'h81};
    in_data  = 8'hA5;
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      if (k <= 16) begin
        chk("last_msb", {v_m, x_m, fd_m}, {1'b1, s16[16-k], k % 8 == 0});
        chk("last_lsb", {v_l, x_l, fd_l}, {1'b1, s16[16-k], k % 8 == 0});
      end else chk("last_end", {v_m, v_l}, 2'b00);
      if (k == 8) begin
        chk("last_hold_empty", rdy_m, 1'b1);
        in_data  = 8'h81;
        in_valid = 1'b1;
      end
      if (k == 9) in_valid = 1'b0;
      cyc();
    end

    // Reset mid-frame with a word held.
    in_data  = 8'hA5;
    in_valid = 1'b1;
    cyc();
    in_data = 8'h3C;
    cyc();
    in_valid = 1'b0;
    cyc();
    cyc();
    chk("mid_held", {rdy_m, busy_m, v_m}, 3'b011);
    #2 rst = 1'b0;
    #1 rst_chk("reset_mid");
    cyc();
    rst_chk("reset_hold");
    #2 rst = 1'b1;
    cyc();
    single(vecs[0]);

    // Random traffic with occasional resets, checked by the model.
    for (int i = 0; i < 3000; i++) begin
      in_valid = $urandom_range(0, 3) != 0;
      in_data  = 8'($urandom);
      if ($urandom_range(0, 199) == 0) begin
        #2 rst = 1'b0;
        #1 rst_chk("reset_rand");
        cyc();
        #2 rst = 1'b1;
      end
      cyc();
    end
    in_valid = 1'b0;
    repeat (3 * W) cyc();
    chk("drain_idle", {v_m, busy_m, v_l, busy_l}, 4'b0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the parallel word width in bits, legal range 2 to 32.
REQ-002 The block SHALL have parameter MSB_FIRST, default 1, where 1 means MSB first and 0 means LSB first.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset; assertion SHALL take effect immediately, and release SHALL be sampled on the next clk edge.
REQ-005 in_data  input  WIDTH  parallel word to serialize.
REQ-006 in_valid  input  1  in_data is offered.
REQ-007 in_ready  output  1  block can accept a word this cycle.
REQ-008 x  output  1  serial bit stream, suitable for direct connection to the downstream sequence detector's x input.
REQ-009 x_valid  output  1  x carries a data bit this cycle.
REQ-010 frame_done  output  1  single-cycle pulse coinciding with the last bit of a word.
REQ-011 busy  output  1  a word is being shifted or is buffered.

Function
REQ-012 A word SHALL be accepted on any rising edge where in_valid=1 and in_ready=1; in_data SHALL be captured at that edge, and later changes to in_data SHALL have no effect on that word.
REQ-013 Internal state SHALL consist of: FSM {IDLE, SHIFT}; a WIDTH-bit shift register; a bit counter cnt (0..WIDTH-1); a one-word hold buffer with a hold_full flag.
REQ-014 in_ready SHALL equal NOT hold_full, decoded from registers only, with no combinational path from in_valid.
REQ-015 In IDLE, an accepted word SHALL load the shift register directly, set cnt=0 and move the FSM to SHIFT, so the first bit appears on x in the next cycle (latency 1).
REQ-016 In SHIFT with cnt<WIDTH-1, each cycle SHALL advance cnt by 1 and shift by one bit toward the output end.
REQ-017 In SHIFT with cnt<WIDTH-1, an accepted word SHALL be written to the hold buffer and hold_full set.
REQ-018 In SHIFT with cnt=WIDTH-1, the next state SHALL be chosen by the first matching rule below, with no idle gap in the first two cases.
REQ-019 Rule 1: if hold_full, the hold word SHALL load into the shift register with cnt=0 and the FSM staying in SHIFT; a word accepted in the same cycle SHALL go into hold, leaving hold_full=1.
REQ-020 Rule 2: else if a word is accepted that cycle, it SHALL load directly into the shift register with cnt=0 and the FSM staying in SHIFT.
REQ-021 Rule 3: otherwise the FSM SHALL go to IDLE.
REQ-022 x SHALL be the shift register MSB when MSB_FIRST=1, or its LSB when MSB_FIRST=0, while in SHIFT, and 0 in IDLE.
REQ-023 x_valid SHALL be 1 exactly when the FSM is in SHIFT.
REQ-024 frame_done SHALL be 1 exactly when the FSM is in SHIFT and cnt=WIDTH-1 (Moore output, decoded from registers).
REQ-025 busy SHALL equal (FSM in SHIFT) OR hold_full.
REQ-026 Words SHALL be emitted in acceptance order, with none lost or duplicated.
REQ-027 Under continuous in_valid, the block SHALL sustain one bit per cycle indefinitely.

Reset
REQ-028 While rst=0, the block SHALL hold: FSM=IDLE, shift register=0, cnt=0, hold_full=0.
REQ-029 While rst=0, outputs SHALL be x=0, x_valid=0, in_ready=1, frame_done=0, busy=0.
REQ-030 A reset mid-frame SHALL abort the current word, discard any hold word and emit no frame_done.

Verification
REQ-031 Reset scenario: drive rst=0 at any time -> outputs x=0, x_valid=0, in_ready=1, frame_done=0, busy=0 immediately.
REQ-032 Single-word scenario: WIDTH=8, MSB_FIRST=1, accept 8'b1001_0110 at cycle 0 -> x=1,0,0,1,0,1,1,0 on cycles 1-8, x_valid=1 on cycles 1-8, frame_done=1 on cycle 8 only, x_valid=0 on cycle 9.
REQ-033 Back-to-back scenario: offer 8'hA5, 8'h3C, 8'hFF with in_valid held high -> 3C goes to hold at cycle 1, in_ready=0 on cycles 2-8, FF is accepted at cycle 9, and 24 contiguous bits appear with frame_done on cycles 8, 16 and 24.
REQ-034 Last-bit scenario: with hold empty, offer 8'h81 exactly on the cycle where cnt=7 -> its first bit appears on x the next cycle, with no x_valid gap.
REQ-035 Mid-frame reset scenario: pulse rst low after 3 bits have been shifted with hold_full=1 -> all outputs take reset values, and after release a new word 8'h01 serializes correctly from bit 0.
REQ-036 LSB-first scenario: MSB_FIRST=0, accept 8'h01 -> x=1 followed by seven 0s, with frame_done on the eighth bit.
